// File: rtl/gpio_pad_bank.sv
// gpio_pad_bank: NCH identical GPIO channels between the SoC GPIO port group
// and the board pad tristate buffers.
//   Output path : registered push-pull or open-drain drive (pad_out/pad_oe).
//   Input path  : SYNC_STAGES-deep synchroniser, optional debounce filter
//                 (DEB_CYCLES consecutive differing samples accept a change),
//                 filtered value gated by gpio_o_ie onto gpio_i_ival.
//   Events      : rise/fall pending flags per channel, set when the filtered
//                 value changes on an input-enabled channel, cleared by
//                 pend_clr (set wins); irq is the OR of all enabled flags.
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   gpio_o_oval/oe/ie              SoC output value, output enable, input enable
//   od_en, deb_en                  per-channel open-drain / debounce select
//   rise_en, fall_en, pend_clr     interrupt masks, pending clear strobe
//   pad_in                         raw asynchronous pin level
//   pad_out, pad_oe                pad buffer value / drive enable
//   gpio_i_ival                    filtered input to SoC
//   rise_pend, fall_pend, irq      pending flags and combined interrupt
module gpio_pad_bank #(
  parameter int unsigned NCH         = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] gpio_o_oval,
  input  logic [NCH-1:0] gpio_o_oe,
  input  logic [NCH-1:0] gpio_o_ie,
  input  logic [NCH-1:0] od_en,
  input  logic [NCH-1:0] deb_en,
  input  logic [NCH-1:0] rise_en,
  input  logic [NCH-1:0] fall_en,
  input  logic [NCH-1:0] pend_clr,
  input  logic [NCH-1:0] pad_in,
  output logic [NCH-1:0] pad_out,
  output logic [NCH-1:0] pad_oe,
  output logic [NCH-1:0] gpio_i_ival,
  output logic [NCH-1:0] rise_pend,
  output logic [NCH-1:0] fall_pend,
  output logic           irq
);

  localparam int unsigned     CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] s;
  logic [NCH-1:0] f_q;
  logic [NCH-1:0] f_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] rise_set;
  logic [NCH-1:0] fall_set;

  // Output drive: open-drain only ever pulls low; a 1 releases the line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pad_out <= '0;
      pad_oe  <= '0;
    end else begin
      pad_out <= gpio_o_oval & ~od_en;
      pad_oe  <= gpio_o_oe & ~(od_en & gpio_o_oval);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pad_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Filter: any cycle where s matches f (or debounce is off) zeroes the count,
  // so a one-cycle bounce restarts the stability window.
  always_comb begin
    f_d = f_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (!deb_en[i]) begin
        f_d[i] = s[i];
      end else if (s[i] != f_q[i]) begin
        if (cnt_q[i] == CNT_LAST) f_d[i] = s[i];
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Edges are taken from the filter's next value so flags update with f.
  assign rise_set = f_d & ~f_q & gpio_o_ie;
  assign fall_set = ~f_d & f_q & gpio_o_ie;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_q       <= '0;
      rise_pend <= '0;
      fall_pend <= '0;
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      f_q       <= f_d;
      rise_pend <= rise_set | (rise_pend & ~pend_clr);
      fall_pend <= fall_set | (fall_pend & ~pend_clr);
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign gpio_i_ival = gpio_o_ie & f_q;
  assign irq         = |((rise_pend & rise_en) | (fall_pend & fall_en));

endmodule

// File: tb/tb_gpio_pad_bank.sv
module tb_gpio_pad_bank;

  localparam int NCH  = 8;
  localparam int SYNC = 2;
  localparam int DEB  = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [NCH-1:0] gpio_o_oval, gpio_o_oe, gpio_o_ie, od_en, deb_en;
  logic [NCH-1:0] rise_en, fall_en, pend_clr, pad_in;
  logic [NCH-1:0] pad_out, pad_oe, gpio_i_ival, rise_pend, fall_pend;
  logic           irq;

  int total = 0;
  int bad   = 0;

  gpio_pad_bank #(.NCH(NCH), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset_n(reset_n),
    .gpio_o_oval(gpio_o_oval), .gpio_o_oe(gpio_o_oe), .gpio_o_ie(gpio_o_ie),
    .od_en(od_en), .deb_en(deb_en), .rise_en(rise_en), .fall_en(fall_en),
    .pend_clr(pend_clr), .pad_in(pad_in),
    .pad_out(pad_out), .pad_oe(pad_oe), .gpio_i_ival(gpio_i_ival),
    .rise_pend(rise_pend), .fall_pend(fall_pend), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pin samples travel through a queue of length SYNC; the filtered level
  // follows the synchronised level once it has differed for DEB samples in a row.
  logic [NCH-1:0] m_hist [$];
  logic [NCH-1:0] m_f, m_rise, m_fall, m_out, m_oe;
  int             m_streak [NCH];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hist.delete();
      for (int k = 0; k < SYNC; k++) m_hist.push_back('0);
      m_f = '0; m_rise = '0; m_fall = '0; m_out = '0; m_oe = '0;
      for (int i = 0; i < NCH; i++) m_streak[i] = 0;
    end else begin
      logic [NCH-1:0] sv, nf;
      sv = m_hist[0];
      nf = m_f;
      for (int i = 0; i < NCH; i++) begin
        if (!deb_en[i]) begin
          nf[i] = sv[i]; m_streak[i] = 0;
        end else if (sv[i] == m_f[i]) begin
          m_streak[i] = 0;
        end else begin
          m_streak[i] = m_streak[i] + 1;
          if (m_streak[i] >= DEB) begin nf[i] = sv[i]; m_streak[i] = 0; end
        end
        if (od_en[i]) begin
          m_out[i] = 1'b0; m_oe[i] = gpio_o_oe[i] && !gpio_o_oval[i];
        end else begin
          m_out[i] = gpio_o_oval[i]; m_oe[i] = gpio_o_oe[i];
        end
        if (pend_clr[i]) begin m_rise[i] = 1'b0; m_fall[i] = 1'b0; end
        if (gpio_o_ie[i] && nf[i] && !m_f[i]) m_rise[i] = 1'b1;
        if (gpio_o_ie[i] && !nf[i] && m_f[i]) m_fall[i] = 1'b1;
      end
      m_f = nf;
      m_hist.push_back(pad_in);
      void'(m_hist.pop_front());
    end
  end

  // Per-cycle compare against the model on the falling edge.
  always @(negedge clk) begin
    logic m_irq;
    m_irq = 1'b0;
    for (int i = 0; i < NCH; i++)
      if ((m_rise[i] && rise_en[i]) || (m_fall[i] && fall_en[i])) m_irq = 1'b1;
    check("pad_out",     32'(pad_out),     32'(m_out));
    check("pad_oe",      32'(pad_oe),      32'(m_oe));
    check("gpio_i_ival", 32'(gpio_i_ival), 32'(gpio_o_ie & m_f));
    check("rise_pend",   32'(rise_pend),   32'(m_rise));
    check("fall_pend",   32'(fall_pend),   32'(m_fall));
    check("irq",         32'(irq),         32'(m_irq));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_all;
    pend_clr = '1; tick(1); pend_clr = '0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n = 1'b0;
    gpio_o_oval = '0; gpio_o_oe = '0; gpio_o_ie = '0; od_en = '0; deb_en = '0;
    rise_en = '0; fall_en = '0; pend_clr = '0; pad_in = '0;
    tick(2);
    reset_n = 1'b1;

    // Make every output nonzero, then assert reset between edges.
    gpio_o_oval = '1; gpio_o_oe = '1; gpio_o_ie = '1; pad_in = '1; rise_en = '1;
    tick(4);
    check("pre_reset_pad_out", 32'(pad_out), 32'h0000_00ff);
    check("pre_reset_irq",     32'(irq),     32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_outs", {pad_out, pad_oe, gpio_i_ival, rise_pend}, 32'h0);
    check("async_reset_irq",  {fall_pend, 7'd0, irq}, 32'h0);
    @(posedge clk); #2 reset_n = 1'b1;
    tick(2);
    check("sync_lat_edge2", 32'(gpio_i_ival), 32'h0000_0000);
    tick(1);
    check("sync_lat_edge3", 32'(gpio_i_ival), 32'h0000_00ff);
    check("sync_rise_pend", 32'(rise_pend),   32'h0000_00ff);

    // Output modes.
    gpio_o_oval = '0; gpio_o_oe = '0; rise_en = '0;
    clear_all();
    gpio_o_oe = 8'h07; gpio_o_oval = 8'h07; od_en = 8'h02;
    tick(1);
    check("pp_od_pad_out", 32'(pad_out), 32'h0000_0005);
    check("pp_od_pad_oe",  32'(pad_oe),  32'h0000_0005);
    gpio_o_oval[1] = 1'b0; od_en[2] = 1'b1;
    tick(1);
    check("od_low_pad_out", 32'(pad_out), 32'h0000_0001);
    check("od_low_pad_oe",  32'(pad_oe),  32'h0000_0003);

    // Debounce on ch4.
    pad_in = '0; tick(4); clear_all();
    deb_en[4] = 1'b1;
    pad_in[4] = 1'b1; tick(15); pad_in[4] = 1'b0;
    tick(20);
    check("glitch15_ival", 32'(gpio_i_ival[4]), 32'h0);
    check("glitch15_rise", 32'(rise_pend[4]),   32'h0);
    pad_in[4] = 1'b1; tick(16); pad_in[4] = 1'b0;
    tick(1);
    check("pulse16_edge17", 32'(gpio_i_ival[4]), 32'h0);
    tick(1);
    check("pulse16_edge18", 32'(gpio_i_ival[4]), 32'h1);
    check("pulse16_rise",   32'(rise_pend[4]),   32'h1);
    tick(20); clear_all();

    // Bounce restarts the window.
    pad_in[4] = 1'b1; tick(10); pad_in[4] = 1'b0; tick(1); pad_in[4] = 1'b1;
    tick(17);
    check("bounce_edge17", 32'(gpio_i_ival[4]), 32'h0);
    tick(1);
    check("bounce_edge18", 32'(gpio_i_ival[4]), 32'h1);
    pad_in[4] = 1'b0; tick(20);

    // Debounce switched off mid-count on ch6.
    deb_en[6] = 1'b1; pad_in[6] = 1'b1;
    tick(8);
    check("deb_off_before", 32'(gpio_i_ival[6]), 32'h0);
    deb_en[6] = 1'b0;
    tick(1);
    check("deb_off_after",  32'(gpio_i_ival[6]), 32'h1);
    pad_in[6] = 1'b0; tick(4);
    deb_en = '0; clear_all();

    // Pending flags and irq on ch3.
    rise_en = 8'h08; fall_en = '0;
    pad_in[3] = 1'b1; tick(3);
    check("ch3_rise_irq", {rise_pend[3], irq}, 32'h3);
    pad_in[3] = 1'b0; tick(3);
    pad_in[3] = 1'b1; tick(2);
    pend_clr[3] = 1'b1; tick(1); pend_clr[3] = 1'b0;
    check("set_wins_rise", 32'(rise_pend[3]), 32'h1);
    check("clr_fall",      32'(fall_pend[3]), 32'h0);
    pend_clr[3] = 1'b1; tick(1); pend_clr[3] = 1'b0;
    check("clr_alone", {rise_pend[3], irq}, 32'h0);
    pad_in[3] = 1'b0; tick(3);
    check("fall_masked", {fall_pend[3], irq}, 32'h2);
    clear_all();

    // Input-enable gating on ch5.
    gpio_o_ie[5] = 1'b0;
    pad_in[5] = 1'b1; tick(4);
    check("gate_ival_hi", 32'(gpio_i_ival[5]), 32'h0);
    pad_in[5] = 1'b0; tick(4);
    pad_in[5] = 1'b1; tick(4);
    check("gate_no_pend", {rise_pend[5], fall_pend[5]}, 32'h0);
    gpio_o_ie[5] = 1'b1;
    #1;
    check("gate_ie_on", 32'(gpio_i_ival[5]), 32'h1);
    tick(2);
    check("gate_no_spurious", {rise_pend[5], fall_pend[5]}, 32'h0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
